// File: rtl/delay_sweep_seq.sv
// Delay sweep sequencer: steps the pulse-generator delay once per point, after a set number of shots.
// Registered outputs update on the edge that samples start/cycle_start/stop; no backpressure; optional SWEEP_REPEAT_EN.
`timescale 1ns/1ps
module delay_sweep_seq #(
    parameter int PTS_W = 16
) (
    input  logic             clk_pll,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cycle_start,
    input  logic [31:0]      base_delay,
    input  logic [31:0]      delay_step,
    input  logic [PTS_W-1:0] num_points,
    input  logic [PTS_W-1:0] shots,
`ifdef SWEEP_REPEAT_EN
    input  logic             repeat_req,
`endif
    output logic [31:0]      delay_out,
    output logic [PTS_W-1:0] point_idx,
    output logic [PTS_W-1:0] shot_idx,
    output logic             busy,
    output logic             point_done,
    output logic             done,
    output logic             sweep_err
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

    localparam logic [PTS_W-1:0] ONE = {{(PTS_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_base;
    logic [31:0]       r_step;
    logic [31:0]       r_delay;
    logic [PTS_W-1:0]  r_num_points;
    logic [PTS_W-1:0]  r_shots;
    logic [PTS_W-1:0]  r_point_idx;
    logic [PTS_W-1:0]  r_shot_idx;
    logic              r_point_done;
    logic              r_done;
    logic              r_err;

    logic              w_load;
    logic              w_err_set;
    logic              w_arm_go;
    logic              w_shot_inc;
    logic              w_pt_adv;
    logic              w_pt_last;
    logic              w_rpt;
    logic              w_last_shot;
    logic              w_last_point;
    logic              w_bad_params;
    logic [32:0]       w_sum;

`ifdef SWEEP_REPEAT_EN
    assign w_rpt = repeat_req;
`else
    assign w_rpt = 1'b0;
`endif

    assign w_sum        = {1'b0, r_delay} + {1'b0, r_step};
    assign w_last_shot  = (r_shot_idx == r_shots - ONE);
    assign w_last_point = (r_point_idx == r_num_points - ONE);
    assign w_bad_params = (num_points == '0) || (shots == '0);

    always_ff @(posedge clk_pll or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // stop outranks everything, including a simultaneous start or point completion
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_err_set  = 1'b0;
        w_arm_go   = 1'b0;
        w_shot_inc = 1'b0;
        w_pt_adv   = 1'b0;
        w_pt_last  = 1'b0;
        if (stop) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_bad_params) begin
                            w_err_set = 1'b1;
                        end else begin
                            w_load = 1'b1;
                            w_next = S_ARM;
                        end
                    end
                end
                S_ARM: begin
                    if (cycle_start) begin
                        w_arm_go = 1'b1;
                        w_next   = S_RUN;
                    end
                end
                S_RUN: begin
                    if (cycle_start) begin
                        if (!w_last_shot) begin
                            w_shot_inc = 1'b1;
                        end else if (!w_last_point) begin
                            w_pt_adv = 1'b1;
                        end else begin
                            w_pt_last = 1'b1;
                            w_next    = w_rpt ? S_RUN : S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    w_next = S_IDLE;
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_pll or negedge reset) begin
        if (!reset) begin
            r_base       <= '0;
            r_step       <= '0;
            r_delay      <= '0;
            r_num_points <= '0;
            r_shots      <= '0;
            r_point_idx  <= '0;
            r_shot_idx   <= '0;
            r_point_done <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_point_done <= 1'b0;
            r_done       <= 1'b0;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_load) begin
                r_base       <= base_delay;
                r_step       <= delay_step;
                r_num_points <= num_points;
                r_shots      <= shots;
                r_delay      <= base_delay;
                r_point_idx  <= '0;
                r_shot_idx   <= '0;
                r_err        <= 1'b0;
            end
            if (w_arm_go) begin
                r_shot_idx <= '0;
            end
            if (w_shot_inc) begin
                r_shot_idx <= r_shot_idx + ONE;
            end
            // delay moves on the completing edge so it settles before the next counter-0
            if (w_pt_adv) begin
                r_point_done <= 1'b1;
                r_shot_idx   <= '0;
                r_point_idx  <= r_point_idx + ONE;
                if (w_sum[32]) begin
                    r_delay <= 32'hFFFF_FFFF;
                    r_err   <= 1'b1;
                end else begin
                    r_delay <= w_sum[31:0];
                end
            end
            if (w_pt_last) begin
                r_point_done <= 1'b1;
                r_done       <= 1'b1;
                r_shot_idx   <= '0;
                if (w_rpt) begin
                    r_delay     <= r_base;
                    r_point_idx <= '0;
                end
            end
        end
    end

    assign delay_out  = r_delay;
    assign point_idx  = r_point_idx;
    assign shot_idx   = r_shot_idx;
    assign busy       = (r_state == S_ARM) || (r_state == S_RUN);
    assign point_done = r_point_done;
    assign done       = r_done;
    assign sweep_err  = r_err;

endmodule

// File: tb/tb_delay_sweep_seq.sv
// Bench for delay_sweep_seq: table of sweep configurations plus hand sequences for stop, reset and repeat.
`timescale 1ns/1ps
module tb_delay_sweep_seq;

    logic        clk_pll = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        cycle_start = 1'b0;
    logic [31:0] base_delay = '0;
    logic [31:0] delay_step = '0;
    logic [15:0] num_points = '0;
    logic [15:0] shots = '0;
`ifdef SWEEP_REPEAT_EN
    logic        repeat_req = 1'b0;
`endif
    logic [31:0] delay_out;
    logic [15:0] point_idx;
    logic [15:0] shot_idx;
    logic        busy;
    logic        point_done;
    logic        done;
    logic        sweep_err;

    delay_sweep_seq #(.PTS_W(16)) dut (
        .clk_pll     (clk_pll),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .cycle_start (cycle_start),
        .base_delay  (base_delay),
        .delay_step  (delay_step),
        .num_points  (num_points),
        .shots       (shots),
`ifdef SWEEP_REPEAT_EN
        .repeat_req  (repeat_req),
`endif
        .delay_out   (delay_out),
        .point_idx   (point_idx),
        .shot_idx    (shot_idx),
        .busy        (busy),
        .point_done  (point_done),
        .done        (done),
        .sweep_err   (sweep_err)
    );

    always #2.5 clk_pll = ~clk_pll;

    typedef struct packed {
        logic [31:0] dly;
        logic [15:0] pidx;
        logic        pd;
        logic        dn;
    } ev_t;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] step;
        logic [15:0] npts;
        logic [15:0] shots;
        logic [31:0] exp_delay;
        logic        exp_err;
        logic        exp_reject;
    } vec_t;

    ev_t  exp_q[$];
    ev_t  mon_ev;
    vec_t vecs[8];
    int   checks = 0;
    int   failures = 0;
    int   pd_cnt = 0;
    int   dn_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_pll);
            #1;
        end
    endtask

    task automatic pulse_cs();
        cycle_start = 1'b1;
        tick();
        cycle_start = 1'b0;
        tick(2);
    endtask

    task automatic push_ev(input logic [31:0] d, input int p, input logic pd, input logic dn);
        ev_t e;
        e.dly  = d;
        e.pidx = 16'(p);
        e.pd   = pd;
        e.dn   = dn;
        exp_q.push_back(e);
    endtask

    // scoreboard side: every point_done/done strobe must match the next queued expectation
    always @(negedge clk_pll) begin
        if (reset && (point_done || done)) begin
            if (point_done) pd_cnt++;
            if (done) dn_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event pd=%0b dn=%0b dly=%0h at %0t", point_done, done, delay_out, $time);
            end else begin
                mon_ev = exp_q.pop_front();
                chk("ev_delay", delay_out, mon_ev.dly);
                chk("ev_point_idx", 32'(point_idx), 32'(mon_ev.pidx));
                chk("ev_point_done", 32'(point_done), 32'(mon_ev.pd));
                chk("ev_done", 32'(done), 32'(mon_ev.dn));
            end
        end
    end

    task automatic run_sweep(input vec_t v);
        int          pd0 = pd_cnt;
        int          dn0 = dn_cnt;
        logic [32:0] s;
        logic [31:0] d = v.base;
        base_delay = v.base;
        delay_step = v.step;
        num_points = v.npts;
        shots      = v.shots;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (v.exp_reject) begin
            chk("rej_busy", 32'(busy), 32'd0);
            chk("rej_err", 32'(sweep_err), 32'd1);
            chk("rej_delay", delay_out, v.exp_delay);
        end else begin
            chk("load_busy", 32'(busy), 32'd1);
            chk("load_err", 32'(sweep_err), 32'd0);
            chk("load_delay", delay_out, v.base);
            chk("load_pidx", 32'(point_idx), 32'd0);
            base_delay = $urandom;
            delay_step = $urandom;
            num_points = 16'($urandom);
            shots      = 16'($urandom);
            pulse_cs();
            for (int p = 0; p < int'(v.npts); p++) begin
                for (int sh = 0; sh < int'(v.shots); sh++) begin
                    if (sh == int'(v.shots) - 1) begin
                        if (p < int'(v.npts) - 1) begin
                            s = {1'b0, d} + {1'b0, v.step};
                            d = s[32] ? 32'hFFFF_FFFF : s[31:0];
                            push_ev(d, p + 1, 1'b1, 1'b0);
                        end else begin
                            push_ev(d, p, 1'b1, 1'b1);
                        end
                    end
                    pulse_cs();
                end
            end
            tick(2);
            chk("end_busy", 32'(busy), 32'd0);
            chk("end_delay", delay_out, v.exp_delay);
            chk("end_err", 32'(sweep_err), 32'(v.exp_err));
            chk("end_pidx", 32'(point_idx), 32'(v.npts - 16'd1));
            chk("end_shot", 32'(shot_idx), 32'd0);
            chk("end_pd_count", 32'(pd_cnt - pd0), 32'(v.npts));
            chk("end_done_count", 32'(dn_cnt - dn0), 32'd1);
        end
    endtask

    initial begin
        int pd0;
        int dn0;
        vecs[0] = '{32'd100, 32'd10, 16'd3, 16'd2, 32'd120, 1'b0, 1'b0};
        vecs[1] = '{32'd7, 32'd3, 16'd3, 16'd0, 32'd120, 1'b1, 1'b1};
        vecs[2] = '{32'hFFFF_FFF0, 32'h20, 16'd2, 16'd1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[3] = '{32'd9, 32'd9, 16'd0, 16'd4, 32'hFFFF_FFFF, 1'b1, 1'b1};
        vecs[4] = '{32'd5, 32'd0, 16'd4, 16'd1, 32'd5, 1'b0, 1'b0};
        vecs[5] = '{32'd0, 32'd1000, 16'd1, 16'd3, 32'd0, 1'b0, 1'b0};
        vecs[6] = '{32'd50, 32'hFFFF_FFC0, 16'd2, 16'd1, 32'hFFFF_FFF2, 1'b0, 1'b0};
        vecs[7] = '{32'd1, 32'hFFFF_FFFF, 16'd2, 16'd2, 32'hFFFF_FFFF, 1'b1, 1'b0};

        tick(3);
        chk("rst_delay", delay_out, 32'd0);
        chk("rst_pidx", 32'(point_idx), 32'd0);
        chk("rst_shot", 32'(shot_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pd", 32'(point_done), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(sweep_err), 32'd0);
        reset = 1'b1;
        tick(2);

        for (int i = 0; i < 8; i++) begin
            run_sweep(vecs[i]);
        end

        // abort: stop arrives with the strobe that would finish point 1, so it must not advance
        pd0 = pd_cnt;
        dn0 = dn_cnt;
        base_delay = 32'd100;
        delay_step = 32'd10;
        num_points = 16'd3;
        shots      = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        base_delay = 32'd999;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_ignored", delay_out, 32'd100);
        pulse_cs();
        pulse_cs();
        chk("shot_inc", 32'(shot_idx), 32'd1);
        push_ev(32'd110, 1, 1'b1, 1'b0);
        pulse_cs();
        chk("pt1_delay", delay_out, 32'd110);
        chk("pt1_shot", 32'(shot_idx), 32'd0);
        pulse_cs();
        cycle_start = 1'b1;
        stop = 1'b1;
        tick();
        cycle_start = 1'b0;
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_delay", delay_out, 32'd110);
        chk("stop_pidx", 32'(point_idx), 32'd1);
        chk("stop_shot", 32'(shot_idx), 32'd1);
        tick(3);
        pulse_cs();
        chk("idle_cs_delay", delay_out, 32'd110);
        chk("idle_cs_pidx", 32'(point_idx), 32'd1);
        chk("stop_pd_count", 32'(pd_cnt - pd0), 32'd1);
        chk("stop_no_done", 32'(dn_cnt - dn0), 32'd0);
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        chk("start_stop_busy", 32'(busy), 32'd0);

        // asynchronous reset in RUN with sweep_err already set
        base_delay = 32'hFFFF_FFF0;
        delay_step = 32'h20;
        num_points = 16'd3;
        shots      = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        pulse_cs();
        push_ev(32'hFFFF_FFFF, 1, 1'b1, 1'b0);
        pulse_cs();
        chk("pre_rst_err", 32'(sweep_err), 32'd1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #0.5;
        reset = 1'b0;
        #0.5;
        chk("arst_delay", delay_out, 32'd0);
        chk("arst_pidx", 32'(point_idx), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_err", 32'(sweep_err), 32'd0);
        tick(2);
        reset = 1'b1;
        tick();
        pulse_cs();
        pulse_cs();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_delay", delay_out, 32'd0);
        chk("post_rst_shot", 32'(shot_idx), 32'd0);

`ifdef SWEEP_REPEAT_EN
        dn0 = dn_cnt;
        base_delay = 32'd100;
        delay_step = 32'd10;
        num_points = 16'd2;
        shots      = 16'd1;
        repeat_req = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        pulse_cs();
        for (int k = 0; k < 3; k++) begin
            push_ev(32'd110, 1, 1'b1, 1'b0);
            pulse_cs();
            push_ev(32'd100, 0, 1'b1, 1'b1);
            pulse_cs();
        end
        chk("rpt_busy", 32'(busy), 32'd1);
        chk("rpt_done_count", 32'(dn_cnt - dn0), 32'd3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat_req = 1'b0;
        chk("rpt_stop_busy", 32'(busy), 32'd0);
`endif

        tick(2);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
